// File: rtl/magnitude_stream.sv
// FFT magnitude stage: floor(sqrt(re^2+im^2)) via an iterative restoring square root,
// scaled and saturated, with valid/ready handshakes, per-frame bin indexing and peak report.
module magnitude_stream #(
  parameter int IN_W      = 25,
  parameter int OUT_W     = 13,
  parameter int SHIFT     = 12,
  parameter int FRAME_LEN = 8192,
  parameter int BIN_W     = $clog2(FRAME_LEN)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sink_valid,
  output logic                   sink_ready,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  input  logic signed [IN_W-1:0] sink_real,
  input  logic signed [IN_W-1:0] sink_imag,
  output logic                   source_valid,
  input  logic                   source_ready,
  output logic [OUT_W-1:0]       source_mag,
  output logic [BIN_W-1:0]       source_bin,
  output logic                   peak_valid,
  output logic [BIN_W-1:0]       peak_bin,
  output logic [OUT_W-1:0]       peak_mag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    ROOT   = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam int              CNT_W     = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);
  localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(FRAME_LEN - 1);
  localparam logic [IN_W-1:0]  MAG_MAX   = IN_W'({OUT_W{1'b1}});

  // Two's-complement magnitude; the most negative value maps to 2^(IN_W-1) unsigned.
  function automatic logic [IN_W-1:0] abs_val(input logic signed [IN_W-1:0] x);
    logic [IN_W-1:0] u;
    u = x;
    if (u[IN_W-1]) abs_val = ~u + IN_W'(1'b1);
    else           abs_val = u;
  endfunction

  function automatic logic [OUT_W-1:0] scale_sat(input logic [IN_W-1:0] m);
    logic [IN_W-1:0] s;
    s = m >> SHIFT;
    if (s > MAG_MAX) scale_sat = {OUT_W{1'b1}};
    else             scale_sat = s[OUT_W-1:0];
  endfunction

  state_t              state_r, state_s;
  logic [IN_W-1:0]     re_r, im_r;
  logic                eop_r;
  logic [BIN_W-1:0]    bin_r, bin_cnt_r, idx_s;
  logic [2*IN_W-1:0]   rad_r, sum_s;
  logic [IN_W+1:0]     rem_r, rem_sh_s, trial_s, rem_next_s;
  logic [IN_W-1:0]     root_r, root_next_s;
  logic [CNT_W-1:0]    iter_r;
  logic                ge_s, accept_s, out_hs_s, root_done_s, frame_end_s;
  logic [OUT_W-1:0]    run_mag_r, cand_mag_s;
  logic [BIN_W-1:0]    run_bin_r, cand_bin_s;

  assign accept_s    = (state_r == IDLE) && sink_valid && sink_ready;
  assign out_hs_s    = (state_r == OUT) && source_valid && source_ready;
  assign root_done_s = (state_r == ROOT) && (iter_r == LAST_ITER);
  assign idx_s       = sink_sop ? {BIN_W{1'b0}} : bin_cnt_r;
  assign sum_s       = ({{IN_W{1'b0}}, re_r} * {{IN_W{1'b0}}, re_r})
                     + ({{IN_W{1'b0}}, im_r} * {{IN_W{1'b0}}, im_r});

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  assign rem_sh_s    = (rem_r << 2) | {{IN_W{1'b0}}, rad_r[2*IN_W-1:2*IN_W-2]};
  assign trial_s     = {root_r, 2'b01};
  assign ge_s        = (rem_sh_s >= trial_s);
  assign rem_next_s  = ge_s ? (rem_sh_s - trial_s) : rem_sh_s;
  assign root_next_s = {root_r[IN_W-2:0], ge_s};
  assign frame_end_s = eop_r || (source_bin == LAST_BIN);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = SQUARE; else state_s = IDLE;
      SQUARE:  state_s = ROOT;
      ROOT:    if (iter_r == LAST_ITER) state_s = OUT; else state_s = ROOT;
      OUT:     if (out_hs_s) state_s = IDLE; else state_s = OUT;
      default: state_s = IDLE;
    endcase
  end

  // Running-peak candidate including the bin currently on the output; ties keep the older bin.
  always_comb begin
    cand_mag_s = run_mag_r;
    cand_bin_s = run_bin_r;
    if ((source_bin == {BIN_W{1'b0}}) || (source_mag > run_mag_r)) begin
      cand_mag_s = source_mag;
      cand_bin_s = source_bin;
    end else begin
      cand_mag_s = run_mag_r;
      cand_bin_s = run_bin_r;
    end
  end

  // Sample capture, squaring and square-root datapath.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      re_r      <= {IN_W{1'b0}};
      im_r      <= {IN_W{1'b0}};
      eop_r     <= 1'b0;
      bin_r     <= {BIN_W{1'b0}};
      bin_cnt_r <= {BIN_W{1'b0}};
      rad_r     <= {(2*IN_W){1'b0}};
      rem_r     <= {(IN_W+2){1'b0}};
      root_r    <= {IN_W{1'b0}};
      iter_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            re_r      <= abs_val(sink_real);
            im_r      <= abs_val(sink_imag);
            eop_r     <= sink_eop;
            bin_r     <= idx_s;
            bin_cnt_r <= (idx_s == LAST_BIN) ? {BIN_W{1'b0}} : idx_s + BIN_W'(1'b1);
          end
        end
        SQUARE: begin
          rad_r  <= sum_s;
          rem_r  <= {(IN_W+2){1'b0}};
          root_r <= {IN_W{1'b0}};
          iter_r <= {CNT_W{1'b0}};
        end
        ROOT: begin
          rad_r  <= rad_r << 2;
          rem_r  <= rem_next_s;
          root_r <= root_next_s;
          iter_r <= iter_r + CNT_W'(1'b1);
        end
        OUT: begin
          rad_r <= rad_r;
        end
        default: begin
          rad_r <= rad_r;
        end
      endcase
    end
  end

  // Registered handshake, magnitude and peak-report outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sink_ready   <= 1'b0;
      source_valid <= 1'b0;
      source_mag   <= {OUT_W{1'b0}};
      source_bin   <= {BIN_W{1'b0}};
      peak_valid   <= 1'b0;
      peak_bin     <= {BIN_W{1'b0}};
      peak_mag     <= {OUT_W{1'b0}};
      run_mag_r    <= {OUT_W{1'b0}};
      run_bin_r    <= {BIN_W{1'b0}};
    end else begin
      sink_ready <= (state_s == IDLE);
      peak_valid <= 1'b0;
      if (root_done_s) begin
        source_valid <= 1'b1;
        source_mag   <= scale_sat(root_next_s);
        source_bin   <= bin_r;
      end else if (out_hs_s) begin
        source_valid <= 1'b0;
        run_mag_r    <= cand_mag_s;
        run_bin_r    <= cand_bin_s;
        if (frame_end_s) begin
          peak_valid <= 1'b1;
          peak_bin   <= cand_bin_s;
          peak_mag   <= cand_mag_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_magnitude_stream.sv
// Directed bench: two instances share stimulus, one with SHIFT=0/FRAME_LEN=4, one with defaults.
module tb_magnitude_stream;

  logic               clk = 1'b0;
  logic               reset_n, sink_valid, sink_sop, sink_eop, source_ready;
  logic signed [24:0] sink_real, sink_imag;

  logic        a_sink_ready, a_source_valid, a_peak_valid;
  logic [12:0] a_source_mag, a_peak_mag;
  logic [1:0]  a_source_bin, a_peak_bin;
  logic        b_sink_ready, b_source_valid, b_peak_valid;
  logic [12:0] b_source_mag, b_peak_mag;
  logic [12:0] b_source_bin, b_peak_bin;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  magnitude_stream #(.SHIFT(0), .FRAME_LEN(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .sink_valid(sink_valid), .sink_ready(a_sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .source_valid(a_source_valid), .source_ready(source_ready), .source_mag(a_source_mag),
    .source_bin(a_source_bin), .peak_valid(a_peak_valid), .peak_bin(a_peak_bin),
    .peak_mag(a_peak_mag)
  );

  magnitude_stream dut_b (
    .clk(clk), .reset_n(reset_n), .sink_valid(sink_valid), .sink_ready(b_sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .source_valid(b_source_valid), .source_ready(source_ready), .source_mag(b_source_mag),
    .source_bin(b_source_bin), .peak_valid(b_peak_valid), .peak_bin(b_peak_bin),
    .peak_mag(b_peak_mag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one bin, wait for acceptance, then count cycles until source_valid.
  task automatic send(input logic [24:0] re, input logic [24:0] im,
                      input logic sop, input logic eop, output int latency);
    int n;
    sink_real  = re;
    sink_imag  = im;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_valid = 1'b1;
    n = 0;
    while (!a_sink_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    latency = 0;
    while (latency < 200) begin
      @(negedge clk);
      latency++;
      if (a_source_valid) break;
    end
  endtask

  task automatic take();
    source_ready = 1'b1;
    @(posedge clk);
    #1;
    source_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int am, input int ab, input int bm, input int bb);
    chk({tag, "_lat"}, lat, 32'd27);
    chk({tag, "_a_mag"}, a_source_mag, am);
    chk({tag, "_a_bin"}, a_source_bin, ab);
    chk({tag, "_b_mag"}, b_source_mag, bm);
    chk({tag, "_b_bin"}, b_source_bin, bb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    source_ready = 1'b0; sink_real = 25'sd0; sink_imag = 25'sd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", a_sink_ready, 32'd0);
    chk("rst_valid", a_source_valid, 32'd0);
    chk("rst_mag", a_source_mag, 32'd0);
    chk("rst_bin", b_source_bin, 32'd0);
    chk("rst_pvalid", b_peak_valid, 32'd0);
    chk("rst_pbin", b_peak_bin, 32'd0);
    chk("rst_pmag", b_peak_mag, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", a_sink_ready, 32'd1);

    // 3-4-5 triangle, sop
    send(25'd3, 25'd4, 1'b1, 1'b0, lat);
    chk_out("t345", 5, 0, 0, 0);
    take();
    chk("t345_a_pv", a_peak_valid, 32'd0);
    chk("t345_b_pv", b_peak_valid, 32'd0);

    // most negative components, one-bin frame
    send(25'h1000000, 25'h1000000, 1'b1, 1'b1, lat);
    chk_out("neg", 8191, 0, 5792, 0);
    take();
    chk("neg_a_pv", a_peak_valid, 32'd1);
    chk("neg_a_pbin", a_peak_bin, 32'd0);
    chk("neg_a_pmag", a_peak_mag, 32'd8191);
    chk("neg_b_pv", b_peak_valid, 32'd1);
    chk("neg_b_pmag", b_peak_mag, 32'd5792);
    @(negedge clk);
    chk("neg_b_pv_drop", b_peak_valid, 32'd0);
    chk("neg_b_pmag_hold", b_peak_mag, 32'd5792);

    // wrapping frame of 4 on dut_a, tie keeps bin 1
    send(25'd1, 25'd0, 1'b1, 1'b0, lat);
    chk_out("f0", 1, 0, 0, 0);
    take();
    chk("f0_a_pv", a_peak_valid, 32'd0);
    send(25'd0, 25'd7, 1'b0, 1'b0, lat);
    chk_out("f1", 7, 1, 0, 1);
    take();
    chk("f1_a_pv", a_peak_valid, 32'd0);
    send(25'd7, 25'd0, 1'b0, 1'b0, lat);
    chk_out("f2", 7, 2, 0, 2);
    take();
    chk("f2_a_pv", a_peak_valid, 32'd0);
    send(25'd2, 25'd2, 1'b0, 1'b0, lat);
    chk_out("f3", 2, 3, 0, 3);
    take();
    chk("f3_a_pv", a_peak_valid, 32'd1);
    chk("f3_a_pbin", a_peak_bin, 32'd1);
    chk("f3_a_pmag", a_peak_mag, 32'd7);
    chk("f3_b_pv", b_peak_valid, 32'd0);
    send(25'd5, 25'd12, 1'b0, 1'b0, lat);
    chk_out("wrap", 13, 0, 0, 4);
    take();

    // sop without valid is ignored; then back-pressure
    sink_sop = 1'b1;
    repeat (2) @(negedge clk);
    sink_sop = 1'b0;
    send(25'd30, 25'd40, 1'b0, 1'b0, lat);
    chk_out("bp", 50, 1, 0, 5);
    for (int i = 0; i < 10; i++) begin
      chk("bp_mag", a_source_mag, 32'd50);
      chk("bp_bin", a_source_bin, 32'd1);
      chk("bp_valid", a_source_valid, 32'd1);
      chk("bp_ready", a_sink_ready, 32'd0);
      @(negedge clk);
    end
    take();
    chk("bp_valid_drop", a_source_valid, 32'd0);
    chk("bp_ready_rise", a_sink_ready, 32'd1);

    // early eop on bin 2 (dut_b magnitudes 3, 9, 5)
    send(25'd12288, 25'd0, 1'b1, 1'b0, lat);
    chk_out("e0", 8191, 0, 3, 0);
    take();
    send(25'd0, 25'd36864, 1'b0, 1'b0, lat);
    chk_out("e1", 8191, 1, 9, 1);
    take();
    send(25'd20480, 25'd0, 1'b0, 1'b1, lat);
    chk_out("e2", 8191, 2, 5, 2);
    take();
    chk("e2_a_pv", a_peak_valid, 32'd1);
    chk("e2_a_pbin", a_peak_bin, 32'd0);
    chk("e2_b_pv", b_peak_valid, 32'd1);
    chk("e2_b_pbin", b_peak_bin, 32'd1);
    chk("e2_b_pmag", b_peak_mag, 32'd9);

    // partial frame (bins 3,4) dropped by a sop at counter 5
    send(25'd28672, 25'd0, 1'b0, 1'b0, lat);
    chk("p3_b", b_source_bin, 32'd3);
    chk("p3_bmag", b_source_mag, 32'd7);
    take();
    chk("p3_b_pv", b_peak_valid, 32'd0);
    send(25'd0, 25'd8192, 1'b0, 1'b0, lat);
    chk("p4_b", b_source_bin, 32'd4);
    take();
    chk("p4_b_pv", b_peak_valid, 32'd0);
    send(25'd4096, 25'd0, 1'b1, 1'b0, lat);
    chk("s0_b", b_source_bin, 32'd0);
    chk("s0_bmag", b_source_mag, 32'd1);
    take();
    chk("s0_b_pv", b_peak_valid, 32'd0);
    send(25'd0, 25'd8192, 1'b0, 1'b1, lat);
    chk("s1_b", b_source_bin, 32'd1);
    take();
    chk("s1_b_pv", b_peak_valid, 32'd1);
    chk("s1_b_pbin", b_peak_bin, 32'd1);
    chk("s1_b_pmag", b_peak_mag, 32'd2);

    // reset while the root iteration is running
    sink_real = 25'd9; sink_imag = 25'd9; sink_valid = 1'b1;
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", a_source_valid, 32'd0);
    chk("mid_rst_ready", a_sink_ready, 32'd0);
    chk("mid_rst_pbin", b_peak_bin, 32'd0);
    chk("mid_rst_pmag", b_peak_mag, 32'd0);
    chk("mid_rst_mag", a_source_mag, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_rise", a_sink_ready, 32'd1);
    send(25'd6, 25'd8, 1'b0, 1'b0, lat);
    chk_out("after_rst", 10, 0, 0, 0);
    take();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
